// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: register numbers, FSM states,
// and the mul/div latency default.
package pipeline_hazard_ctrl_pkg;

  localparam int unsigned REG_NUM_W          = 5;
  localparam int unsigned MD_LATENCY_DEFAULT = 32;
  localparam int unsigned MD_COUNT_W         = $clog2(MD_LATENCY_DEFAULT);

  typedef logic [REG_NUM_W-1:0]  RegNumPath;
  typedef logic [MD_COUNT_W-1:0] MdCountPath;

  typedef enum logic [1:0] {
    RUN,
    LOAD_STALL,
    MD_BUSY
  } HazardStatePath;

endpackage

// File: rtl/pipeline_hazard_ctrl_md_latency_counter.sv
// Down-counter that tracks the remaining EX cycles of a mul/div op.
// Loads a start value, decrements without wrapping, and flags zero.
module md_latency_counter #(
  parameter int unsigned CNT_WIDTH = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [CNT_WIDTH-1:0] loadValue,
  input  logic                 dec,
  output logic [CNT_WIDTH-1:0] cnt,
  output logic                 zero
);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= loadValue;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - CNT_WIDTH'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencer: load-use bubbles, taken-branch flushes and mul/div holds.
// Optional performance counters are enabled with HAZARD_PERF_CNT_EN.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int unsigned REG_NUM_WIDTH  = REG_NUM_W,
  parameter int unsigned MD_LATENCY     = MD_LATENCY_DEFAULT,
  parameter int unsigned PERF_CNT_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [REG_NUM_WIDTH-1:0] ifidRSOut,
  input  logic [REG_NUM_WIDTH-1:0] ifidRTOut,
  input  logic                     ifidUsesRT,
  input  logic                     idexMemRdOut,
  input  logic [REG_NUM_WIDTH-1:0] idexRDOut,
  input  logic                     idexMdOpOut,
  input  logic                     exBrTaken,
  output logic                     pcWrEnable,
  output logic                     ifidWrEnable,
  output logic                     idexWrEnable,
  output logic                     ifidFlush,
  output logic                     idexFlush,
  output logic                     exmemFlush,
  output logic                     mdBusy,
`ifdef HAZARD_PERF_CNT_EN
  output logic [PERF_CNT_WIDTH-1:0] stallCycleCnt,
  output logic [PERF_CNT_WIDTH-1:0] flushCnt,
`endif
  output logic                     mdDone
);

  localparam int unsigned CntW = $clog2(MD_LATENCY);

  if (MD_LATENCY < 2) begin : gMdLatencyCheck
    $error("MD_LATENCY must be at least 2");
  end
  if (PERF_CNT_WIDTH < 1) begin : gPerfWidthCheck
    $error("PERF_CNT_WIDTH must be at least 1");
  end

  HazardStatePath state, stateNext;
  logic           loadUse;
  logic           cntLoad, cntDec, cntZero;
  logic [CntW-1:0] cnt;

  // $zero is never a real producer, and RT only matters when ID actually reads it.
  assign loadUse = idexMemRdOut && (idexRDOut != '0) &&
                   ((idexRDOut == ifidRSOut) || (ifidUsesRT && (idexRDOut == ifidRTOut)));

  md_latency_counter #(.CNT_WIDTH(CntW)) uMdCnt (
    .clk       (clk),
    .rst       (rst),
    .load      (cntLoad),
    .loadValue (CntW'(MD_LATENCY - 2)),
    .dec       (cntDec),
    .cnt       (cnt),
    .zero      (cntZero)
  );

  // Next state and stage controls; all outputs fall back to free-running while rst is high.
  always_comb begin
    stateNext    = state;
    pcWrEnable   = 1'b1;
    ifidWrEnable = 1'b1;
    idexWrEnable = 1'b1;
    ifidFlush    = 1'b0;
    idexFlush    = 1'b0;
    exmemFlush   = 1'b0;
    mdBusy       = 1'b0;
    mdDone       = 1'b0;
    cntLoad      = 1'b0;
    cntDec       = 1'b0;
    if (!rst) begin
      case (state)
        RUN: begin
          if (idexMdOpOut) begin
            pcWrEnable   = 1'b0;
            ifidWrEnable = 1'b0;
            idexWrEnable = 1'b0;
            exmemFlush   = 1'b1;
            mdBusy       = 1'b1;
            cntLoad      = 1'b1;
            stateNext    = MD_BUSY;
          end else if (exBrTaken) begin
            ifidFlush = 1'b1;
            idexFlush = 1'b1;
          end else if (loadUse) begin
            pcWrEnable   = 1'b0;
            ifidWrEnable = 1'b0;
            idexFlush    = 1'b1;
            stateNext    = LOAD_STALL;
          end
        end
        LOAD_STALL: stateNext = RUN;
        MD_BUSY: begin
          mdBusy = 1'b1;
          cntDec = 1'b1;
          if (cntZero) begin
            mdDone    = 1'b1;
            stateNext = RUN;
          end else begin
            pcWrEnable   = 1'b0;
            ifidWrEnable = 1'b0;
            idexWrEnable = 1'b0;
            exmemFlush   = 1'b1;
          end
        end
        default: stateNext = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
    end else begin
      state <= stateNext;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  // Saturating event counters for stall and flush cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      stallCycleCnt <= '0;
      flushCnt      <= '0;
    end else begin
      if (!pcWrEnable && (stallCycleCnt != '1)) begin
        stallCycleCnt <= stallCycleCnt + PERF_CNT_WIDTH'(1);
      end
      if (ifidFlush && (flushCnt != '1)) begin
        flushCnt <= flushCnt + PERF_CNT_WIDTH'(1);
      end
    end
  end
`endif

endmodule
